// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores retire into a circular FIFO, drain in order through a ready
// handshake, and loads are forwarded from the youngest matching entry.
// A small flush FSM drains the buffer to empty on request.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     stall,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wd,
  input  logic                     mem_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   addr_mem_q [DEPTH];
  logic [AW-1:0]   addr_mem_d [DEPTH];
  logic [DW-1:0]   data_mem_q [DEPTH];
  logic [DW-1:0]   data_mem_d [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic unused_ld_lsb;

  // The byte offset of a load never takes part in word matching.
  assign unused_ld_lsb = ^ld_addr[1:0];

  // Handshake terms; stall depends only on registered state and st_valid.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    stall    = (full & st_valid) | (state_q == DRAIN);
    push     = st_valid & ~stall;
    mem_we   = ~empty;
    pop      = mem_we & mem_ready;
    mem_addr = addr_mem_q[head_q];
    mem_wd   = data_mem_q[head_q];
    count    = count_q;
  end

  // Pointer, occupancy and entry-write next-state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      addr_mem_d[tail_q] = st_addr;
      data_mem_d[tail_q] = st_data;
      tail_d             = tail_q + PW'(1);
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (addr_mem_q[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_mem_q[idx];
      end
    end
  end

  // Flush FSM next-state and done pulse.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        // Pushes are blocked here, so count_d==0 covers both the
        // last pop and an already-empty buffer on entry.
        if (count_d == '0) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: pointers, count and FSM, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted as valid.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule
